checkpoint_ctrl: RTL and testbench
==================================

# checkpoint_ctrl

Checkpoint controller directly downstream of the save-point sprite stage. It consumes the per-pixel `save_s` activation code and collapses it into one save event per activation. It records the active checkpoint and drives the "saved" sprite select back to the save stage. It also runs the death/restart/respawn handshake that hands respawn coordinates to the kid motion logic.

## Interface
Parameters:
- START_X, 10'd40: respawn X when no checkpoint is recorded
- START_Y, 10'd440: respawn Y when no checkpoint is recorded
- SPAWN0_X, 10'd270: respawn X for slot 0
- SPAWN0_Y, 10'd440: respawn Y for slot 0
- SPAWN1_X, 10'd625: respawn X for slot 1
- SPAWN1_Y, 10'd290: respawn Y for slot 1
- HOLD_FRAMES, 8'd30: number of frames the "saved" sprite is held

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-Clk pulse per video frame
- save_s  in  2  from save stage: 01 = slot 0, 10 = slot 1, 00 = none; 11 is ignored
- kid_dead  in  1  level; kid has died
- restart_req  in  1  level; restart key held
- respawn_ack  in  1  kid logic has accepted the respawn coordinates
- save_exist  out  1  enable to save stage
- saved_slot  out  2  last recorded checkpoint (00 = none)
- flash_slot  out  2  slot whose "saved" sprite is shown; 00 = none
- respawn_valid  out  1  respawn coordinates valid
- respawn_x  out  10  respawn X coordinate
- respawn_y  out  10  respawn Y coordinate
- save_count  out  8  number of accepted saves; saturates at 255

## Operation
- All outputs are registered.
- FSM states and transitions:
  - PLAY → DEAD when kid_dead = 1.
  - PLAY → RESPAWN when restart_req = 1 and kid_dead = 0.
  - DEAD → RESPAWN when restart_req = 1.
  - RESPAWN → PLAY when respawn_ack = 1.
- save_exist = 1 only in PLAY.
- respawn_valid = 1 only in RESPAWN.
- Arming:
  - A `seen` flag sets on any cycle with save_s ∈ {01, 10}.
  - On frame_tick, armed ← 1 if `seen` was 0 and save_s is also 0 in that cycle. Otherwise armed stays as is.
  - `seen` clears on frame_tick, then takes the current cycle's sample.
  - Net effect: a save re-arms only after one full frame with no activation.
- Save accept: requires state = PLAY, armed = 1, save_s ∈ {01, 10}, and kid_dead = 0. On accept, in one cycle:
  - saved_slot ← save_s
  - flash_slot ← save_s
  - flash counter ← HOLD_FRAMES
  - save_count ← save_count + 1, saturating at 255
  - armed ← 0
- Flash:
  - On frame_tick with counter > 0, decrement the counter.
  - When the counter reaches 0, flash_slot ← 00.
  - A new accept reloads the counter and flash_slot.
  - Flash continues counting in DEAD and RESPAWN.
- Respawn coordinates, updated every cycle from saved_slot:
  - 00 → START
  - 01 → SPAWN0
  - 10 → SPAWN1
- Simultaneous events:
  - kid_dead together with save_s: death wins; the save is discarded.
  - restart_req together with kid_dead in PLAY: go to DEAD. RESPAWN follows on the next cycle if restart_req is still held.
  - respawn_ack outside RESPAWN: ignored.
  - save_s = 11: treated as 00.
- Reset, at any time including mid-respawn:
  - state = PLAY, save_exist = 1, armed = 1, seen = 0
  - saved_slot = 00, flash_slot = 00, flash counter = 0, save_count = 0
  - respawn_valid = 0, respawn_x = START_X, respawn_y = START_Y
- Checkpoint retention: saved_slot persists across death and respawn; only Reset clears it.

## Timing
- Save accept latency: save_s sampled at edge N → saved_slot, flash_slot, and save_count updated after edge N. Visible in cycle N+1.
- Restart latency: restart_req sampled at edge N in PLAY or DEAD → respawn_valid = 1 and save_exist = 0 from cycle N+1.
- Respawn handshake:
  - respawn_valid, respawn_x, and respawn_y are held stable until acknowledged.
  - respawn_ack sampled high at edge N while valid → respawn_valid = 0 and save_exist = 1 from cycle N+1.
  - Ack on the same edge that valid rises is not possible, because valid is registered.
- Flash duration: exactly HOLD_FRAMES frame_tick pulses after the accept. A frame_tick in the accept cycle does not decrement the counter.
- Throughput: at most one accept per two frames. A continuous save_s burst across frames never re-arms.

## Test plan
- Reset, then save_s = 01 for 20 cycles within one frame → saved_slot = 01, save_count = 1, flash_slot = 01; only one accept.
- Hold save_s bursts on every frame for 5 frames → save_count stays 1. Then one idle frame, then a burst → save_count = 2.
- After accept, run 30 frame_ticks → flash_slot = 00 exactly after the 30th tick; saved_slot remains 01.
- save_s = 10 and kid_dead same cycle → no accept, state DEAD. Then restart_req → next cycle respawn_valid = 1, (x, y) = (40, 440). Hold ack low 10 cycles → valid and coordinates stable. Ack → PLAY, save_exist = 1.
- Save slot 1, die, restart → respawn (625, 290). Assert Reset during RESPAWN → valid = 0, saved_slot = 00, respawn (40, 440), save_count = 0.
- Force 256 accepts (idle frame between each) → save_count saturates at 255.

Source files
------------

// File: rtl/checkpoint_ctrl.sv
// Checkpoint controller: turns save-stage activations into single save events,
// tracks the recorded checkpoint and runs the death/restart/respawn handshake.
module checkpoint_ctrl #(
  parameter logic [9:0] START_X     = 10'd40,
  parameter logic [9:0] START_Y     = 10'd440,
  parameter logic [9:0] SPAWN0_X    = 10'd270,
  parameter logic [9:0] SPAWN0_Y    = 10'd440,
  parameter logic [9:0] SPAWN1_X    = 10'd625,
  parameter logic [9:0] SPAWN1_Y    = 10'd290,
  parameter logic [7:0] HOLD_FRAMES = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [1:0] save_s,
  input  logic       kid_dead,
  input  logic       restart_req,
  input  logic       respawn_ack,
  output logic       save_exist,
  output logic [1:0] saved_slot,
  output logic [1:0] flash_slot,
  output logic       respawn_valid,
  output logic [9:0] respawn_x,
  output logic [9:0] respawn_y,
  output logic [7:0] save_count
);

  typedef enum logic [1:0] {PLAY, DEAD, RESPAWN} state_t;

  state_t     state;
  logic       seen;
  logic       armed;
  logic [7:0] flash_cnt;

  logic       save_hit;
  logic       accept;
  logic [1:0] slot_next;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;

  // Coordinates follow the slot being written this cycle so they never shift
  // under an already-raised respawn_valid.
  always_comb begin
    save_hit  = (save_s == 2'b01) || (save_s == 2'b10);
    accept    = (state == PLAY) && armed && save_hit && !kid_dead;
    slot_next = accept ? save_s : saved_slot;
    spawn_x   = START_X;
    spawn_y   = START_Y;
    case (slot_next)
      2'b01: begin
        spawn_x = SPAWN0_X;
        spawn_y = SPAWN0_Y;
      end
      2'b10: begin
        spawn_x = SPAWN1_X;
        spawn_y = SPAWN1_Y;
      end
      default: begin
        spawn_x = START_X;
        spawn_y = START_Y;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= PLAY;
      save_exist    <= 1'b1;
      respawn_valid <= 1'b0;
      seen          <= 1'b0;
      armed         <= 1'b1;
      saved_slot    <= 2'b00;
      flash_slot    <= 2'b00;
      flash_cnt     <= 8'd0;
      save_count    <= 8'd0;
      respawn_x     <= START_X;
      respawn_y     <= START_Y;
    end else begin
      case (state)
        PLAY: begin
          if (kid_dead) begin
            state      <= DEAD;
            save_exist <= 1'b0;
          end else if (restart_req) begin
            state         <= RESPAWN;
            save_exist    <= 1'b0;
            respawn_valid <= 1'b1;
          end
        end
        DEAD: begin
          if (restart_req) begin
            state         <= RESPAWN;
            respawn_valid <= 1'b1;
          end
        end
        RESPAWN: begin
          if (respawn_ack) begin
            state         <= PLAY;
            respawn_valid <= 1'b0;
            save_exist    <= 1'b1;
          end
        end
        default: begin
          state         <= PLAY;
          save_exist    <= 1'b1;
          respawn_valid <= 1'b0;
        end
      endcase

      // Re-arm only after a whole frame passed with no activation at all.
      seen <= frame_tick ? save_hit : (seen | save_hit);
      if (accept)
        armed <= 1'b0;
      else if (frame_tick && !seen && !save_hit)
        armed <= 1'b1;

      if (accept) begin
        flash_slot <= save_s;
        flash_cnt  <= HOLD_FRAMES;
        if (save_count != 8'hFF)
          save_count <= save_count + 8'd1;
      end else if (frame_tick && (flash_cnt != 8'd0)) begin
        flash_cnt <= flash_cnt - 8'd1;
        if (flash_cnt == 8'd1)
          flash_slot <= 2'b00;
      end

      saved_slot <= slot_next;
      respawn_x  <= spawn_x;
      respawn_y  <= spawn_y;
    end
  end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Randomised and directed bench for checkpoint_ctrl against a frame-level
// behavioural model of saves, flash hold and the respawn handshake.
module tb_checkpoint_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] save_s = 2'b00;
  logic       kid_dead = 1'b0;
  logic       restart_req = 1'b0;
  logic       respawn_ack = 1'b0;

  logic       save_exist;
  logic [1:0] saved_slot;
  logic [1:0] flash_slot;
  logic       respawn_valid;
  logic [9:0] respawn_x;
  logic [9:0] respawn_y;
  logic [7:0] save_count;

  int checks = 0;
  int errors = 0;

  checkpoint_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .save_s(save_s),
    .kid_dead(kid_dead), .restart_req(restart_req), .respawn_ack(respawn_ack),
    .save_exist(save_exist), .saved_slot(saved_slot), .flash_slot(flash_slot),
    .respawn_valid(respawn_valid), .respawn_x(respawn_x), .respawn_y(respawn_y),
    .save_count(save_count)
  );

  always #5 Clk = ~Clk;

  // 32-cycle frames; the tick changes on the falling edge so it is stable at sampling.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge Clk);
      frame_tick = (cyc % 32 == 31);
      cyc++;
    end
  end

  // Model: mode 0 = playing, 1 = dead, 2 = waiting for respawn acceptance.
  int m_mode, m_slot, m_flash, m_left, m_count;
  bit m_seen, m_armed;
  bit started = 1'b0;

  function automatic int coordX(int slot);
    return (slot == 1) ? 270 : (slot == 2) ? 625 : 40;
  endfunction

  function automatic int coordY(int slot);
    return (slot == 2) ? 290 : 440;
  endfunction

  always @(posedge Clk) begin : model
    int sv;
    bit acc;
    if (Reset) begin
      m_mode = 0; m_slot = 0; m_flash = 0; m_left = 0; m_count = 0;
      m_seen = 0; m_armed = 1; started = 1;
    end else if (started) begin
      sv = (save_s == 2'd1 || save_s == 2'd2) ? int'(save_s) : 0;
      acc = (m_mode == 0) && m_armed && (sv != 0) && !kid_dead;
      if (acc) begin
        m_slot = sv; m_flash = sv; m_left = 30; m_armed = 0;
        m_count = (m_count < 255) ? m_count + 1 : 255;
      end else if (frame_tick && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_flash = 0;
      end
      if (frame_tick) begin
        if (!m_seen && sv == 0) m_armed = 1;
        m_seen = (sv != 0);
      end else if (sv != 0) begin
        m_seen = 1;
      end
      if (m_mode == 0 && kid_dead) m_mode = 1;
      else if (m_mode != 2 && restart_req) m_mode = 2;
      else if (m_mode == 2 && respawn_ack) m_mode = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge Clk) begin
    if (started) begin
      checkOutput("save_exist", 32'(save_exist), 32'(m_mode == 0));
      checkOutput("respawn_valid", 32'(respawn_valid), 32'(m_mode == 2));
      checkOutput("saved_slot", 32'(saved_slot), m_slot);
      checkOutput("flash_slot", 32'(flash_slot), m_flash);
      checkOutput("save_count", 32'(save_count), m_count);
      checkOutput("respawn_x", 32'(respawn_x), coordX(m_slot));
      checkOutput("respawn_y", 32'(respawn_y), coordY(m_slot));
    end
  end

  task automatic applyStimulus(input logic [1:0] s, input logic dead,
                               input logic rreq, input logic ack, input int n);
    save_s = s; kid_dead = dead; restart_req = rreq; respawn_ack = ack;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 2);
    Reset = 1'b0;
  endtask

  task automatic waitTick();
    int guard;
    guard = 0;
    do begin
      @(posedge Clk);
      #1;
      guard++;
    end while (!frame_tick && guard < 80);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_wait: got no tick, expected tick within 80 cycles");
    end
  endtask

  initial begin
    doReset();
    checkOutput("rst_save_exist", 32'(save_exist), 1);
    checkOutput("rst_respawn_x", 32'(respawn_x), 40);
    checkOutput("rst_respawn_y", 32'(respawn_y), 440);
    checkOutput("rst_save_count", 32'(save_count), 0);

    waitTick();
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("first_slot", 32'(saved_slot), 1);
    checkOutput("first_count", 32'(save_count), 1);
    checkOutput("first_flash", 32'(flash_slot), 1);

    waitTick();
    for (int f = 0; f < 5; f++) begin
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 10);
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1);
      waitTick();
    end
    checkOutput("burst_count", 32'(save_count), 1);
    waitTick();
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("rearm_count", 32'(save_count), 2);

    for (int t = 0; t < 29; t++) waitTick();
    checkOutput("flash_29", 32'(flash_slot), 1);
    waitTick();
    checkOutput("flash_30", 32'(flash_slot), 0);
    checkOutput("flash_slot_kept", 32'(saved_slot), 1);

    doReset();
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("death_wins_slot", 32'(saved_slot), 0);
    checkOutput("death_exist", 32'(save_exist), 0);
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("restart_valid", 32'(respawn_valid), 1);
    checkOutput("restart_x", 32'(respawn_x), 40);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 10);
    checkOutput("hold_valid", 32'(respawn_valid), 1);
    checkOutput("hold_y", 32'(respawn_y), 440);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("ack_exist", 32'(save_exist), 1);
    checkOutput("ack_valid", 32'(respawn_valid), 0);

    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("slot1_saved", 32'(saved_slot), 2);
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("slot1_x", 32'(respawn_x), 625);
    checkOutput("slot1_y", 32'(respawn_y), 290);
    Reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1);
    Reset = 1'b0;
    checkOutput("midrst_valid", 32'(respawn_valid), 0);
    checkOutput("midrst_slot", 32'(saved_slot), 0);
    checkOutput("midrst_x", 32'(respawn_x), 40);
    checkOutput("midrst_count", 32'(save_count), 0);

    for (int k = 0; k < 256; k++) begin
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 0);
      waitTick();
      waitTick();
    end
    checkOutput("saturate_count", 32'(save_count), 255);

    for (int f = 0; f < 120; f++) begin
      bit active;
      active = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 32; c++) begin
        Reset = ($urandom_range(0, 299) == 0);
        applyStimulus((active && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 19) == 0) ? ~kid_dead : kid_dead,
                      ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), 1);
      end
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
